// File: rtl/gcd_unit.sv
// gcd_unit: iterative 16-bit greatest-common-divisor engine.
//
// Operands arrive serially on data_in after a start pulse: A on the cycle
// after start is sampled, then B on the following cycle. The engine then
// subtracts the smaller register from the larger, one step per cycle, until
// the two match. It then holds the result in A with done high.
//
// Ports
//   clk      in   1  single clock, rising edge
//   rst      in   1  synchronous active-high reset
//   start    in   1  begin a new computation (sampled in IDLE and DONE)
//   data_in  in  16  operand bus: A, then B on the next cycle
//   done     out  1  high while a valid result is held
//   gcd_out  out 16  result (the A register), valid while done is high
//
// state  | meaning
// IDLE   | waiting for start after reset
// LOAD_A | capture A from data_in
// LOAD_B | capture B from data_in
// RUN    | one subtract/compare step per cycle
// DONE   | result held in A, done high, waiting for the next start

module gcd_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] data_in,
    output logic        done,
    output logic [15:0] gcd_out
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] reg_a;
    logic [15:0] reg_b;
    logic [15:0] a_next;
    logic [15:0] b_next;
    logic [15:0] diff;

    logic        lt;
    logic        gt;
    logic        eq;
    logic        a_zero;
    logic        b_zero;
    logic        sub_b_minus_a;

    // Comparator flags for A versus B. lt is implied by the priority order
    // in RUN, so it is only used to choose the subtractor's operand order.
    assign lt     = (reg_a < reg_b);
    assign gt     = (reg_a > reg_b);
    assign eq     = (reg_a == reg_b);
    assign a_zero = (reg_a == 16'd0);
    assign b_zero = (reg_b == 16'd0);

    // A single shared subtractor. The controller always asks for larger minus
    // smaller, so the result can never underflow.
    assign diff = sub_b_minus_a ? (reg_b - reg_a) : (reg_a - reg_b);

    always_comb begin
        state_next    = state;
        a_next        = reg_a;
        b_next        = reg_b;
        sub_b_minus_a = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD_A;
                end
            end
            LOAD_A: begin
                a_next     = data_in;
                state_next = LOAD_B;
            end
            LOAD_B: begin
                b_next     = data_in;
                state_next = RUN;
            end
            RUN: begin
                if (b_zero || eq) begin
                    // gcd(x,0)=x and gcd(x,x)=x: A already holds the result.
                    state_next = DONE;
                end else if (a_zero) begin
                    // gcd(0,x)=x: move B into A so the result lives in A.
                    a_next     = reg_b;
                    state_next = DONE;
                end else if (gt) begin
                    a_next = diff;
                end else begin
                    sub_b_minus_a = lt;
                    b_next        = diff;
                end
            end
            DONE: begin
                if (start) begin
                    state_next = LOAD_A;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            reg_a <= 16'd0;
            reg_b <= 16'd0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            reg_a <= a_next;
            reg_b <= b_next;
            // Registered copy of the state decode, so done is high exactly
            // while the state register holds DONE.
            done  <= (state_next == DONE);
        end
    end

    assign gcd_out = reg_a;

endmodule

// File: tb/tb_gcd_unit.sv
// tb_gcd_unit: randomized, scoreboard-checked bench for gcd_unit.
//
// Each run pushes the expected result and the cycle on which done should
// first be seen into a queue; a monitor on the falling edge pops an entry
// whenever done rises and compares both. Expected values come from a
// remainder-based Euclid model that also counts subtraction steps.

module tb_gcd_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] data_in;
    logic        done;
    logic [15:0] gcd_out;

    int total;
    int bad;
    int cyc;

    typedef struct {
        int res;
        int when;
    } exp_t;

    exp_t exp_q[$];

    gcd_unit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data_in (data_in),
        .done    (done),
        .gcd_out (gcd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        total = total + 1;
        if (actual != expected) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference: gcd and number of subtraction cycles, from quotients.
    function automatic void model(input int a_in, input int b_in, output int g, output int n);
        int a;
        int b;
        int q;
        int r;
        a = a_in;
        b = b_in;
        n = 0;
        g = 0;
        if (a == 0 || b == 0) begin
            g = a + b;
            return;
        end
        forever begin
            if (a == b) begin
                g = a;
                return;
            end
            if (a > b) begin
                q = a / b;
                r = a % b;
                if (r == 0) begin
                    n = n + q - 1;
                    g = b;
                    return;
                end
                n = n + q;
                a = r;
            end else begin
                q = b / a;
                r = b % a;
                if (r == 0) begin
                    n = n + q - 1;
                    g = a;
                    return;
                end
                n = n + q;
                b = r;
            end
        end
    endfunction

    // Monitor: every rising done must match the oldest queued expectation.
    logic done_q;
    initial done_q = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            done_q = 1'b0;
        end else begin
            if (done && !done_q) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result", int'(gcd_out), e.res);
                    check("done_cycle", cyc, e.when);
                end
            end
            done_q = done;
        end
    end

    // Called at a falling edge with the DUT in IDLE or DONE. Returns at the
    // falling edge where done is first seen high (or after a timeout).
    task automatic run(input int a, input int b, input bit toggle, input bit keep_start,
                       output int g);
        int   n;
        exp_t e;
        int   waited;
        model(a, b, g, n);
        start = 1'b1;
        // Edge k is the next rising edge; done must be seen after edge k+3+n.
        e.res  = g;
        e.when = cyc + 1 + 3 + n;
        exp_q.push_back(e);
        @(negedge clk);
        check("done_low_after_start", int'(done), 0);
        data_in = 16'(a);
        start   = toggle ? 1'($urandom) : 1'b0;
        @(negedge clk);
        data_in = 16'(b);
        start   = toggle ? 1'($urandom) : 1'b0;
        waited  = 0;
        forever begin
            @(negedge clk);
            data_in = 16'($urandom);
            if (done) begin
                start = keep_start;
                break;
            end
            start  = toggle ? 1'($urandom) : 1'b0;
            waited = waited + 1;
            if (waited > n + 10) begin
                check("done_timeout", 0, 1);
                start = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        int g;
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        start   = 1'b0;
        data_in = 16'd0;

        repeat (3) @(negedge clk);
        check("reset_done", int'(done), 0);
        check("reset_gcd_out", int'(gcd_out), 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases, with expected latency from the model.
        run(12, 24, 1'b0, 1'b0, g);
        run(24, 12, 1'b0, 1'b0, g);
        run(13, 7,  1'b0, 1'b0, g);
        run(0,  9,  1'b0, 1'b0, g);
        run(9,  0,  1'b0, 1'b0, g);
        run(0,  0,  1'b0, 1'b0, g);
        run(5,  5,  1'b0, 1'b0, g);

        // Reset in the middle of a long computation.
        start = 1'b1;
        @(negedge clk);
        data_in = 16'd65535;
        start   = 1'b0;
        @(negedge clk);
        data_in = 16'd1;
        repeat (20) @(negedge clk);
        check("run_before_reset_done", int'(done), 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrun_reset_done", int'(done), 0);
        check("midrun_reset_gcd_out", int'(gcd_out), 0);
        rst = 1'b0;
        run(8, 12, 1'b0, 1'b0, g);

        // Result held stable in DONE, then a pulsed restart.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_done", int'(done), 1);
            check("hold_gcd_out", int'(gcd_out), 4);
        end
        run(21, 14, 1'b0, 1'b0, g);

        // start held high: each result is visible for one cycle only.
        run(30, 18, 1'b0, 1'b1, g);
        run(40, 25, 1'b0, 1'b1, g);
        run(7,  49, 1'b0, 1'b0, g);

        // start toggling during loads and RUN must not disturb anything.
        run(13, 7,  1'b1, 1'b0, g);
        run(100, 75, 1'b1, 1'b0, g);

        // Randomized operands, occasionally zero, with random start noise.
        for (int i = 0; i < 25; i++) begin
            int a;
            int b;
            a = int'($urandom_range(0, 600));
            b = int'($urandom_range(0, 600));
            if ($urandom_range(0, 7) == 0) a = 0;
            if ($urandom_range(0, 7) == 0) b = 0;
            run(a, b, 1'($urandom), 1'b0, g);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
